pipe_muldiv_unit: RTL
=====================

Name: pipe_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers. It sits beside the ALU in the Execute stage of the 5-stage pipeline. It adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support and a busy/stall handshake to the hazard unit. Width is generic so the same unit serves 16/32/64-bit datapath builds.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high
StartE  in  1  issue strobe from Execute stage
OpE  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others ignored
SrcAE  in  WIDTH  rs operand (multiplicand/dividend/MT data)
SrcBE  in  WIDTH  rt operand (multiplier/divisor)
HiLoReadD  in  1  MFHI/MFLO present in Decode
AbortE  in  1  flush: kill in-flight operation
Busy  out  1  operation in progress
Done  out  1  one-cycle pulse when HI/LO updated by MULT/DIV
StallMD  out  1  to hazard unit: stall F/D
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any state): Hi=0, Lo=0, Busy=0, Done=0, StallMD=0, FSM=IDLE, counter=0.
- FSM states IDLE, CALC, FIX.
- IDLE + StartE + OpE in {MULT,MULTU,DIV,DIVU}: latch operands; signed ops take magnitudes and record result signs (quotient sign = sign A xor sign B, remainder sign = sign A, product sign = sign A xor sign B). Next state CALC, counter=WIDTH, Busy=1 from next cycle.
- IDLE + StartE + MTHI/MTLO: Hi (or Lo) <= SrcAE at the next edge. No Busy, no Done.
- CALC: one iteration per cycle. Multiply is shift-add, 2*WIDTH accumulator. Divide is restoring, one quotient bit per cycle. Counter decrements; at 1 go to FIX.
- FIX: apply two's-complement sign correction (unsigned ops pass through). Write Hi/Lo. Done=1 for this single cycle. Next state IDLE, Busy=0.
- Latency: start edge to Hi/Lo valid = WIDTH+2 cycles (34 for WIDTH=32). Busy is high for WIDTH+1 cycles.
- Multiply result: Hi = upper WIDTH bits of product, Lo = lower WIDTH bits.
- Divide result: Lo = quotient (truncating toward zero), Hi = remainder.
- Divide by zero: Lo = all ones, Hi = dividend (SrcAE as given). Still takes the full latency.
- Signed MIN / -1: Lo = MIN, Hi = 0 (natural wrap of the magnitude algorithm).
- StartE while Busy: ignored. The request is not queued; StallMD covers it.
- StallMD = Busy & (HiLoReadD | StartE), combinational.
- AbortE in CALC/FIX: return to IDLE next edge. Hi/Lo unchanged, Done not asserted, Busy=0.
- AbortE with StartE in the same IDLE cycle: abort wins, nothing starts (MT writes are suppressed too).
- Hi/Lo reads are always the register value. There is no bypass of in-flight results.

Decomposition:
- Package pipe_md_pkg holds:
  - op encodings (MD_MULT..MD_MTLO)
  - state enum md_state_t {IDLE, CALC, FIX}
  - divide-by-zero quotient constant
- One sub-module, md_shift_core. It holds the 2*WIDTH shift register and the WIDTH+1-bit add/subtract for both algorithms, with a mul/div select and a step enable.
- The FSM, sign handling and Hi/Lo registers stay in the top level.

Test Plan:
- WIDTH=32, MULT SrcA=-3 (FFFFFFFD), SrcB=5 -> after 34 cycles Hi=FFFFFFFF, Lo=FFFFFFF1, Done pulses once, Busy high 33 cycles.
- DIVU 100/7 -> Lo=0000000E, Hi=00000002. DIV -7/2 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
- DIV 123/0 -> Lo=FFFFFFFF, Hi=0000007B. DIV 80000000/FFFFFFFF -> Lo=80000000, Hi=0.
- MULTU FFFFFFFF*FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001. Second StartE (DIVU) at cycle 5 is ignored, with StallMD=1 that cycle. HiLoReadD held -> StallMD=1 until Busy falls.
- Start MULT 7*9, AbortE at cycle 10 -> Busy=0 next cycle, Done never pulses, Hi/Lo keep prior values. Then MTLO 0000ABCD -> Lo=0000ABCD one cycle later.
- Assert reset asynchronously mid-CALC (between edges) -> Hi=Lo=0 and Busy=Done=0 immediately. After release, MULT 2*3 completes normally with Lo=6 at WIDTH=16 (latency 18).

Source files
------------

// File: rtl/pipe_md_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and the divide-by-zero quotient.
package pipe_md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    // All ones, sliced down to the datapath width by the user.
    localparam logic [127:0] MD_DIV0_QUO = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } md_state_t;

endpackage

// File: rtl/md_shift_core.sv
// Shared 2*WIDTH shift register and WIDTH+1-bit adder/subtractor that runs
// one shift-add multiply step or one restoring-divide step per enabled cycle.
module md_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     add_x, add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic               no_borrow;

    always_comb begin
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        // Divide subtracts the divisor from the shifted remainder; the carry-out
        // then doubles as "remainder >= divisor".
        if (is_div) begin
            add_x   = rem_shift;
            add_y   = ~{1'b0, b_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_y   = {1'b0, b_q};
            add_cin = 1'b0;
        end
        add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
        no_borrow = add_sum[WIDTH+1];

        acc_d = acc_q;
        b_d   = b_q;
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, op_a};
            b_d   = op_b;
        end else if (step) begin
            if (is_div) begin
                acc_d = {(no_borrow ? add_sum[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], no_borrow};
            end else if (acc_q[0]) begin
                acc_d = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/pipe_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit with HI/LO registers and a
// busy/stall handshake. Signed ops run on magnitudes and are fixed up at the end.
module pipe_muldiv_unit
    import pipe_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             StartE,
    input  logic [2:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiLoReadD,
    input  logic             AbortE,
    output logic             Busy,
    output logic             Done,
    output logic             StallMD,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               core_load, core_step;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_shift_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (is_div_q),
        .op_a   (a_mag),
        .op_b   (b_mag),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    always_comb begin
        op_signed = ~OpE[0];
        a_mag     = (op_signed && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        b_mag     = (op_signed && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
        prod_mag  = {acc_hi, acc_lo};
        prod_fix  = neg_res_q ? -prod_mag : prod_mag;
        // Negating |A| restores the original dividend, so a zero divisor
        // leaves the remainder path untouched and only the quotient is forced.
        quo_fix   = div_zero_q ? MD_DIV0_QUO[WIDTH-1:0] : (neg_res_q ? -acc_lo : acc_lo);
        rem_fix   = neg_rem_q ? -acc_hi : acc_hi;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        core_load  = 1'b0;
        core_step  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (StartE && !AbortE) begin
                    case (OpE)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            core_load  = 1'b1;
                            state_d    = CALC;
                            cnt_d      = CNT_W'(WIDTH);
                            is_div_d   = OpE[1];
                            neg_res_d  = op_signed & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                            neg_rem_d  = op_signed & SrcAE[WIDTH-1];
                            div_zero_d = (SrcBE == '0);
                        end
                        MD_MTHI: hi_d = SrcAE;
                        MD_MTLO: lo_d = SrcAE;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (AbortE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!AbortE) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign Busy    = (state_q != IDLE);
    assign Done    = done_q;
    assign StallMD = Busy & (HiLoReadD | StartE);
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule
